// File: rtl/pwm_shadow_cmp_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_shadow_cmp_if
//  Description : Configuration handshake bundle for pwm_shadow_cmp. The
//                master offers a new period/duty pair with cfg_valid. The
//                slave takes it when cfg_ready is high.
//  Signals     : cfg_valid  - new configuration offered (master -> slave)
//                cfg_ready  - shadow register free      (slave -> master)
//                cfg_period - requested period, 0 means 256
//                cfg_duty   - requested duty, high clocks per period
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_shadow_cmp_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_period;
    logic [7:0] cfg_duty;

    modport master (
        output cfg_valid,
        output cfg_period,
        output cfg_duty,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_period,
        input  cfg_duty,
        output cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/pwm_shadow_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_shadow_cmp
//  Description : Compare stage that follows a free-running modulus counter.
//                The counter counts 1..N and wraps to 1, where N=0 means 256.
//                This block drives the counter's modulus and produces a
//                registered PWM pair. New period/duty values enter a shadow
//                register through a valid/ready handshake. They become active
//                only on the wrap edge, so every PWM period is complete.
//  Ports       : clk, reset     - clock, asynchronous active-high reset
//                cnt            - current counter value
//                period         - active period (counter modulus)
//                cfg            - configuration handshake (slave side)
//                pwm, pwm_n     - PWM output and its complement
//                period_tick    - one-clock pulse at the start of each period
//                upd_done       - one-clock pulse when the shadow is applied
//  Options     : PWM_DEADTIME_EN - when defined, both outputs are held low
//                for DEAD_CYCLES clocks after every raw transition.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_shadow_cmp #(
    parameter logic [7:0] RST_PERIOD  = 8'd100,
    parameter logic [7:0] RST_DUTY    = 8'd50,
    parameter logic [3:0] DEAD_CYCLES = 4'd2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic [7:0]    cnt,
    output logic [7:0]         period,
    pwm_shadow_cmp_if.slave    cfg,
    output logic               pwm,
    output logic               pwm_n,
    output logic               period_tick,
    output logic               upd_done
);

    logic [7:0] r_act_period;
    logic [7:0] r_act_duty;
    logic [7:0] r_shd_period;
    logic [7:0] r_shd_duty;
    logic       r_pending;
    logic       r_raw;
    logic       r_period_tick;
    logic       r_upd_done;

    logic [8:0] w_ce;
    logic       w_wrap;
    logic       w_xfer;
    logic       w_apply;
    logic       w_raw_next;

    // A count of 0 stands for 256, so the compare runs on 9 bits.
    assign w_ce = (cnt == 8'd0) ? 9'd256 : {1'b0, cnt};

    // Raw 8-bit equality is the same wrap test the counter uses. A period
    // of 0 therefore wraps when cnt reaches 0 (the 256th count).
    assign w_wrap  = (cnt == r_act_period);
    assign w_xfer  = cfg.cfg_valid && !r_pending;
    assign w_apply = w_wrap && r_pending;

    // The old active duty is used on the wrap edge. The new duty first
    // affects the compare for count 1.
    assign w_raw_next = (r_act_duty != 8'd0) && (w_ce <= {1'b0, r_act_duty});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_act_period  <= RST_PERIOD;
            r_act_duty    <= RST_DUTY;
            r_shd_period  <= 8'd0;
            r_shd_duty    <= 8'd0;
            r_pending     <= 1'b0;
            r_raw         <= 1'b0;
            r_period_tick <= 1'b0;
            r_upd_done    <= 1'b0;
        end else begin
            r_raw         <= w_raw_next;
            r_period_tick <= w_wrap;
            r_upd_done    <= w_apply;
            // Apply and transfer cannot coincide: a transfer needs an empty
            // shadow, and an apply needs a full one. Data captured on a wrap
            // edge therefore waits for the following wrap.
            if (w_apply) begin
                r_act_period <= r_shd_period;
                r_act_duty   <= r_shd_duty;
                r_pending    <= 1'b0;
            end else if (w_xfer) begin
                r_shd_period <= cfg.cfg_period;
                r_shd_duty   <= cfg.cfg_duty;
                r_pending    <= 1'b1;
            end
        end
    end

    assign period        = r_act_period;
    assign cfg.cfg_ready = !r_pending;
    assign period_tick   = r_period_tick;
    assign upd_done      = r_upd_done;

`ifdef PWM_DEADTIME_EN
    logic [3:0] r_dt;

    // The counter reloads whenever raw is about to change. Both outputs stay
    // low until it drains to zero. It resets loaded, so pwm_n starts low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dt <= DEAD_CYCLES;
        end else if (w_raw_next != r_raw) begin
            r_dt <= DEAD_CYCLES;
        end else if (r_dt != 4'd0) begin
            r_dt <= r_dt - 4'd1;
        end
    end

    assign pwm   =  r_raw & (r_dt == 4'd0);
    assign pwm_n = ~r_raw & (r_dt == 4'd0);
`else
    // The dead-time length only matters when the dead-time stage is built.
    logic w_unused_dead;
    assign w_unused_dead = ^DEAD_CYCLES;

    assign pwm   =  r_raw;
    assign pwm_n = ~r_raw;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_shadow_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_shadow_cmp
//  Description : Directed testbench for pwm_shadow_cmp. It includes a model
//                of the upstream modulus counter that is driven by the DUT's
//                period output. PWM periods are measured between period_tick
//                pulses and compared with hand-computed tables.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_shadow_cmp;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cnt;
    logic [7:0] period;
    logic       pwm, pwm_n, period_tick, upd_done;

    pwm_shadow_cmp_if cfg_if ();

    pwm_shadow_cmp dut (
        .clk        (clk),
        .reset      (reset),
        .cnt        (cnt),
        .period     (period),
        .cfg        (cfg_if),
        .pwm        (pwm),
        .pwm_n      (pwm_n),
        .period_tick(period_tick),
        .upd_done   (upd_done)
    );

    always #5 clk = ~clk;

    // Upstream counter: counts 1..period, wraps to 1, and 0 means 256.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              cnt <= 8'd1;
        else if (cnt == period) cnt <= 8'd1;
        else                    cnt <= cnt + 8'd1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

`ifdef PWM_DEADTIME_EN
    localparam int DEAD = 2;
`endif

    // Converts the raw high count into the pwm high count seen on the pin.
    function automatic int adj(input int h, input int len);
`ifdef PWM_DEADTIME_EN
        if (h == 0 || h == len) return h;
        return (h > DEAD) ? h - DEAD : 0;
`else
        return (h > len) ? len : h;
`endif
    endfunction

    function automatic int exp_first(input int h, input int len);
`ifdef PWM_DEADTIME_EN
        return (h == len) ? 1 : 0;
`else
        return (h > 0 && len > 0) ? 1 : 0;
`endif
    endfunction

    typedef struct {
        int len;
        int highs;
        int upds;
        int shape_err;
        int pair_err;
        int first_pwm;
        int end_period;
        int rdy_before;
        int rdy_after;
    } meas_t;

    // Call this right after a period_tick sample. It samples one period up to
    // and including the next tick. It can also offer a config on sample inj_at.
    task automatic measure(input int inj_at, input logic [7:0] ip,
                           input logic [7:0] id, output meas_t m);
        bit seen_high = 1'b0;
        bit seen_fall = 1'b0;
        m = '{default: 0};
        m.rdy_before = -1;
        m.rdy_after  = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            m.len = i;
            if (pwm)      m.highs++;
            if (upd_done) m.upds++;
            if (i == 1)   m.first_pwm = int'(pwm);
            if (pwm && seen_fall) m.shape_err++;
            if (pwm)       seen_high = 1'b1;
            else if (seen_high) seen_fall = 1'b1;
`ifdef PWM_DEADTIME_EN
            if (pwm && pwm_n) m.pair_err++;
`else
            if (pwm_n !== ~pwm) m.pair_err++;
`endif
            if (i == inj_at + 1) begin
                cfg_if.cfg_valid = 1'b0;
                m.rdy_after = int'(cfg_if.cfg_ready);
            end
            if (i == inj_at) begin
                m.rdy_before = int'(cfg_if.cfg_ready);
                cfg_if.cfg_valid  = 1'b1;
                cfg_if.cfg_period = ip;
                cfg_if.cfg_duty   = id;
            end
            if (period_tick) begin
                m.end_period = int'(period);
                break;
            end
        end
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_tick(output int ok, output int upds);
        ok = 0;
        upds = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (upd_done) upds++;
            if (period_tick) begin
                ok = 1;
                return;
            end
        end
    endtask

    task automatic wait_upd(output int ok, output int tick, output int per);
        ok = 0;
        tick = 0;
        per = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (upd_done) begin
                ok = 1;
                tick = int'(period_tick);
                per = int'(period);
                return;
            end
        end
    endtask

    task automatic send_cfg(input logic [7:0] p, input logic [7:0] d, output int rdy_after);
        rdy_after = -1;
        @(negedge clk);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_period = p;
        cfg_if.cfg_duty   = d;
        for (int i = 0; i < 600; i++) begin
            if (cfg_if.cfg_ready) begin
                @(negedge clk);
                cfg_if.cfg_valid = 1'b0;
                rdy_after = int'(cfg_if.cfg_ready);
                return;
            end
            @(negedge clk);
        end
        cfg_if.cfg_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0] p;
        logic [7:0] d;
        int         exp_len;
        int         exp_high;
    } vec_t;

    vec_t vecs[4];

    initial begin
        meas_t m, m1, m2;
        int ok, u, tk, per, ra, eh;

        vecs[0] = '{p: 8'd20, d: 8'd0,   exp_len: 20,  exp_high: 0};
        vecs[1] = '{p: 8'd20, d: 8'd255, exp_len: 20,  exp_high: 20};
        vecs[2] = '{p: 8'd0,  d: 8'd200, exp_len: 256, exp_high: 200};
        vecs[3] = '{p: 8'd5,  d: 8'd4,   exp_len: 5,   exp_high: 4};

        reset = 1'b1;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_period = 8'd0;
        cfg_if.cfg_duty   = 8'd0;
        repeat (3) @(negedge clk);

        check("rst_period", int'(period), 100);
        check("rst_ready", int'(cfg_if.cfg_ready), 1);
        check("rst_pwm", int'(pwm), 0);
`ifdef PWM_DEADTIME_EN
        check("rst_pwm_n", int'(pwm_n), 0);
`else
        check("rst_pwm_n", int'(pwm_n), 1);
`endif
        check("rst_tick", int'(period_tick), 0);
        check("rst_upd", int'(upd_done), 0);
        reset = 1'b0;

        // Free-running default configuration.
        wait_tick(ok, u);
        check("first_tick", ok, 1);
        measure(-1, 8'd0, 8'd0, m);
        check("def_len", m.len, 100);
        check("def_high", m.highs, adj(50, 100));
        check("def_first", m.first_pwm, exp_first(50, 100));
        check("def_shape", m.shape_err, 0);
        check("def_pair", m.pair_err, 0);
        check("def_upd", m.upds, 0);

        // Mid-period transfer: the current period finishes unchanged.
        measure(30, 8'd20, 8'd5, m);
        check("mid_rdy_before", m.rdy_before, 1);
        check("mid_rdy_drop", m.rdy_after, 0);
        check("mid_old_len", m.len, 100);
        check("mid_old_high", m.highs, adj(50, 100));
        check("mid_upd_at_wrap", m.upds, 1);
        check("mid_new_period", m.end_period, 20);
        measure(-1, 8'd0, 8'd0, m);
        check("mid_new_len", m.len, 20);
        check("mid_new_high", m.highs, adj(5, 20));
        check("mid_new_shape", m.shape_err, 0);
        check("mid_upd_once", m.upds, 0);
        check("mid_ready_back", int'(cfg_if.cfg_ready), 1);

        // Transfer on the exact wrap edge: old values hold for one more period.
        measure(19, 8'd7, 8'd3, m);
        check("wrap_rdy_before", m.rdy_before, 1);
        check("wrap_rdy_drop", m.rdy_after, 0);
        check("wrap_no_upd", m.upds, 0);
        check("wrap_hold_period", m.end_period, 20);
        measure(-1, 8'd0, 8'd0, m);
        check("wrap_old_len", m.len, 20);
        check("wrap_old_high", m.highs, adj(5, 20));
        check("wrap_late_upd", m.upds, 1);
        check("wrap_new_period", m.end_period, 7);
        measure(-1, 8'd0, 8'd0, m);
        check("wrap_new_len", m.len, 7);
        check("wrap_new_high", m.highs, adj(3, 7));

        // Table of boundary configurations.
        for (int v = 0; v < 4; v++) begin
            send_cfg(vecs[v].p, vecs[v].d, ra);
            check($sformatf("v%0d_rdy_drop", v), ra, 0);
            wait_upd(ok, tk, per);
            check($sformatf("v%0d_upd_seen", v), ok, 1);
            check($sformatf("v%0d_upd_on_tick", v), tk, 1);
            check($sformatf("v%0d_period", v), per, int'(vecs[v].p));
            measure(-1, 8'd0, 8'd0, m1);
            measure(-1, 8'd0, 8'd0, m2);
            eh = adj(vecs[v].exp_high, vecs[v].exp_len);
            check($sformatf("v%0d_len", v), m2.len, vecs[v].exp_len);
            check($sformatf("v%0d_high", v), m2.highs, eh);
            check($sformatf("v%0d_first", v), m2.first_pwm, exp_first(eh, vecs[v].exp_len));
            check($sformatf("v%0d_shape", v), m2.shape_err, 0);
            check($sformatf("v%0d_pair", v), m1.pair_err + m2.pair_err, 0);
            check($sformatf("v%0d_no_upd", v), m1.upds + m2.upds, 0);
        end

        // Reset while a shadow is pending: the shadow is discarded.
        send_cfg(8'd50, 8'd10, ra);
        check("rp_rdy_drop", ra, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rp_ready", int'(cfg_if.cfg_ready), 1);
        check("rp_period", int'(period), 100);
        reset = 1'b0;
        wait_tick(ok, u);
        check("rp_tick", ok, 1);
        check("rp_no_upd", u, 0);
        measure(-1, 8'd0, 8'd0, m);
        check("rp_len", m.len, 100);
        check("rp_high", m.highs, adj(50, 100));
        check("rp_upd", m.upds, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
